// File: rtl/ex_result_reg.sv
// ex_result_reg: two-entry in-order buffer between the execute stage and
// writeback. It holds a main (head) entry and a skid entry, each carrying
// {result, destination, write enable}. It also owns the {Z,N,C} condition-code
// register, which updates when a result is accepted.
//
// Ports:
//   CLK, RST        clock, asynchronous active-high reset
//   IN_VALID/READY  upstream handshake; IN_READY is registered (skid empty)
//   R_IN, Z_IN, N_IN, C_IN, FUNC_IN, DEST_IN, WE_IN, SETF_IN
//                   execute result, flags and control for the incoming entry
//   OUT_VALID/READY downstream handshake; OUT_VALID = main entry occupied
//   R_OUT, DEST_OUT, WE_OUT
//                   head entry fields (WE_OUT gated with OUT_VALID)
//   FLAGS           condition-code register {Z,N,C}
module ex_result_reg #(
  parameter int DATAWIDTH = 16,
  parameter int REGBITS   = 3,
  parameter int FUNCBITS  = 3
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  input  logic [DATAWIDTH-1:0] R_IN,
  input  logic                 Z_IN,
  input  logic                 N_IN,
  input  logic                 C_IN,
  input  logic [FUNCBITS-1:0]  FUNC_IN,
  input  logic [REGBITS-1:0]   DEST_IN,
  input  logic                 WE_IN,
  input  logic                 SETF_IN,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic [DATAWIDTH-1:0] R_OUT,
  output logic [REGBITS-1:0]   DEST_OUT,
  output logic                 WE_OUT,
  output logic [2:0]           FLAGS
);

  logic                 main_valid_q, main_valid_d;
  logic [DATAWIDTH-1:0] main_r_q, main_r_d;
  logic [REGBITS-1:0]   main_dest_q, main_dest_d;
  logic                 main_we_q, main_we_d;
  logic                 skid_valid_q, skid_valid_d;
  logic [DATAWIDTH-1:0] skid_r_q, skid_r_d;
  logic [REGBITS-1:0]   skid_dest_q, skid_dest_d;
  logic                 skid_we_q, skid_we_d;
  logic [2:0]           flags_q, flags_d;

  logic accept;
  logic consume;
  logic keep_carry;

  assign accept  = IN_VALID & ~skid_valid_q;
  assign consume = main_valid_q & OUT_READY;

  // Logical operations (100, 101, 110) leave the carry flag untouched.
  assign keep_carry = (FUNC_IN == FUNCBITS'(4)) ||
                      (FUNC_IN == FUNCBITS'(5)) ||
                      (FUNC_IN == FUNCBITS'(6));

  always_comb begin
    main_valid_d = main_valid_q;
    main_r_d     = main_r_q;
    main_dest_d  = main_dest_q;
    main_we_d    = main_we_q;
    skid_valid_d = skid_valid_q;
    skid_r_d     = skid_r_q;
    skid_dest_d  = skid_dest_q;
    skid_we_d    = skid_we_q;
    flags_d      = flags_q;

    if (skid_valid_q) begin
      // Full: nothing can be accepted; a consume promotes the skid entry.
      if (consume) begin
        main_r_d     = skid_r_q;
        main_dest_d  = skid_dest_q;
        main_we_d    = skid_we_q;
        skid_valid_d = 1'b0;
      end
    end else if (!main_valid_q || consume) begin
      // Main is free (or freed this cycle): a new entry lands there.
      // Without an accept the data fields hold their last value.
      main_valid_d = accept;
      if (accept) begin
        main_r_d    = R_IN;
        main_dest_d = DEST_IN;
        main_we_d   = WE_IN;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_r_d     = R_IN;
      skid_dest_d  = DEST_IN;
      skid_we_d    = WE_IN;
    end

    if (accept && SETF_IN) begin
      flags_d[2] = Z_IN;
      flags_d[1] = N_IN;
      flags_d[0] = keep_carry ? flags_q[0] : C_IN;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      main_valid_q <= 1'b0;
      main_r_q     <= '0;
      main_dest_q  <= '0;
      main_we_q    <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_r_q     <= '0;
      skid_dest_q  <= '0;
      skid_we_q    <= 1'b0;
      flags_q      <= 3'b000;
    end else begin
      main_valid_q <= main_valid_d;
      main_r_q     <= main_r_d;
      main_dest_q  <= main_dest_d;
      main_we_q    <= main_we_d;
      skid_valid_q <= skid_valid_d;
      skid_r_q     <= skid_r_d;
      skid_dest_q  <= skid_dest_d;
      skid_we_q    <= skid_we_d;
      flags_q      <= flags_d;
    end
  end

  // IN_READY comes straight from a flop, so it never sees OUT_READY.
  assign IN_READY  = ~skid_valid_q;
  assign OUT_VALID = main_valid_q;
  assign R_OUT     = main_r_q;
  assign DEST_OUT  = main_dest_q;
  assign WE_OUT    = main_valid_q & main_we_q;
  assign FLAGS     = flags_q;

endmodule

// File: tb/tb_ex_result_reg.sv
module tb_ex_result_reg;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        IN_VALID = 1'b0;
  logic        IN_READY;
  logic [15:0] R_IN = '0;
  logic        Z_IN = 1'b0, N_IN = 1'b0, C_IN = 1'b0;
  logic [2:0]  FUNC_IN = '0;
  logic [2:0]  DEST_IN = '0;
  logic        WE_IN = 1'b0;
  logic        SETF_IN = 1'b0;
  logic        OUT_VALID;
  logic        OUT_READY = 1'b0;
  logic [15:0] R_OUT;
  logic [2:0]  DEST_OUT;
  logic        WE_OUT;
  logic [2:0]  FLAGS;

  ex_result_reg #(.DATAWIDTH(16), .REGBITS(3), .FUNCBITS(3)) dut (
    .CLK(CLK), .RST(RST),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .R_IN(R_IN), .Z_IN(Z_IN), .N_IN(N_IN), .C_IN(C_IN),
    .FUNC_IN(FUNC_IN), .DEST_IN(DEST_IN), .WE_IN(WE_IN), .SETF_IN(SETF_IN),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .R_OUT(R_OUT), .DEST_OUT(DEST_OUT), .WE_OUT(WE_OUT), .FLAGS(FLAGS)
  );

  always #5 CLK = ~CLK;

  // Reference model: an ordered queue of at most two entries, plus the
  // value last shown at the head (held after the buffer drains).
  typedef struct {
    logic [15:0] r;
    logic [2:0]  dest;
    logic        we;
  } ent_t;

  ent_t        mq[$];
  logic [15:0] m_r;
  logic [2:0]  m_dest;
  logic        m_z, m_n, m_c;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_r = '0; m_dest = '0;
    m_z = 1'b0; m_n = 1'b0; m_c = 1'b0;
  endtask

  task automatic check_all(input string tag);
    check({tag, "_in_ready"},  32'(IN_READY),  32'(mq.size() < 2));
    check({tag, "_out_valid"}, 32'(OUT_VALID), 32'(mq.size() > 0));
    check({tag, "_r_out"},     32'(R_OUT),     32'(m_r));
    check({tag, "_dest_out"},  32'(DEST_OUT),  32'(m_dest));
    check({tag, "_we_out"},    32'(WE_OUT),    32'((mq.size() > 0) && mq[0].we));
    check({tag, "_flags"},     32'(FLAGS),     32'({m_z, m_n, m_c}));
  endtask

  task automatic drive(input logic v, input logic [15:0] r, input logic [2:0] dest,
                       input logic we, input logic setf, input logic [2:0] func,
                       input logic z, input logic n, input logic c, input logic ordy);
    IN_VALID = v; R_IN = r; DEST_IN = dest; WE_IN = we; SETF_IN = setf;
    FUNC_IN = func; Z_IN = z; N_IN = n; C_IN = c; OUT_READY = ordy;
  endtask

  // One clock: decide the handshakes from the pre-edge inputs, then apply
  // them to the model once the edge has passed.
  task automatic tick();
    bit   acc, con;
    ent_t e;
    acc = IN_VALID && (mq.size() < 2);
    con = OUT_READY && (mq.size() > 0);
    e.r = R_IN; e.dest = DEST_IN; e.we = WE_IN;
    if (acc && SETF_IN) begin
      m_z = Z_IN;
      m_n = N_IN;
      if (FUNC_IN < 3'd4 || FUNC_IN == 3'd7) m_c = C_IN;
    end
    @(posedge CLK);
    #1;
    if (con) void'(mq.pop_front());
    if (acc) mq.push_back(e);
    if (mq.size() > 0) begin
      m_r = mq[0].r;
      m_dest = mq[0].dest;
    end
  endtask

  task automatic pulse_reset(input string tag);
    #3;
    RST = 1'b1;
    #1;
    model_reset();
    check({tag, "_rst_out_valid"}, 32'(OUT_VALID), 32'(0));
    check({tag, "_rst_flags"},     32'(FLAGS),     32'(0));
    check({tag, "_rst_in_ready"},  32'(IN_READY),  32'(1));
    check_all({tag, "_rst"});
    #1;
    RST = 1'b0;
  endtask

  initial begin
    model_reset();
    #1;
    check_all("reset_hold");
    #20;
    RST = 1'b0;
    @(posedge CLK); #1;
    check_all("after_reset");

    // Single pass
    drive(1, 16'h1234, 3'd5, 1, 1, 3'b000, 0, 0, 1, 1);
    tick();
    check("single_out_valid", 32'(OUT_VALID), 32'(1));
    check("single_r_out",     32'(R_OUT),     32'h1234);
    check("single_dest",      32'(DEST_OUT),  32'(5));
    check("single_we",        32'(WE_OUT),    32'(1));
    check("single_flags",     32'(FLAGS),     32'b001);
    check_all("single");
    drive(0, 16'h0, 3'd0, 0, 0, 3'b000, 0, 0, 0, 1);
    tick();
    check_all("single_drain");

    // Fill and drain with a stalled output
    drive(1, 16'h0001, 3'd1, 1, 0, 3'b000, 0, 0, 0, 0);
    tick();
    drive(1, 16'h0002, 3'd2, 0, 0, 3'b000, 0, 0, 0, 0);
    tick();
    check("fill_in_ready", 32'(IN_READY), 32'(0));
    check("fill_r_out",    32'(R_OUT),    32'h0001);
    check_all("fill2");
    drive(1, 16'h0003, 3'd3, 1, 1, 3'b000, 1, 1, 0, 0);
    tick();
    check("fill_ignored_r", 32'(R_OUT), 32'h0001);
    check("fill_ignored_flags", 32'(FLAGS), 32'b001);
    check_all("fill3");
    drive(0, 16'h0, 3'd0, 0, 0, 3'b000, 0, 0, 0, 1);
    tick();
    check("drain_first", 32'(R_OUT), 32'h0002);
    check_all("drain1");
    tick();
    check("drain_empty", 32'(OUT_VALID), 32'(0));
    check("drain_hold_r", 32'(R_OUT), 32'h0002);
    check_all("drain2");

    // Streaming
    for (int i = 0; i < 8; i++) begin
      drive(1, 16'(16'h0100 + i), 3'(i), 1, 0, 3'b000, 0, 0, 0, 1);
      tick();
      check("stream_r_out", 32'(R_OUT), 32'(16'h0100 + i));
      check("stream_in_ready", 32'(IN_READY), 32'(1));
      check_all("stream");
    end

    // Carry retention and SETF=0
    drive(1, 16'h0, 3'd0, 0, 1, 3'b000, 0, 0, 1, 1);
    tick();
    check("carry_base", 32'(FLAGS), 32'b001);
    drive(1, 16'h0, 3'd0, 0, 1, 3'b100, 1, 0, 0, 1);
    tick();
    check("carry_keep", 32'(FLAGS), 32'b101);
    drive(1, 16'h0, 3'd0, 0, 1, 3'b111, 0, 0, 0, 1);
    tick();
    check("carry_shift", 32'(FLAGS), 32'b000);
    drive(1, 16'h0, 3'd0, 0, 0, 3'b001, 1, 1, 1, 1);
    tick();
    check("setf_zero", 32'(FLAGS), 32'b000);
    check_all("flags");

    // Reset with two entries held and FLAGS=110
    drive(1, 16'hAAAA, 3'd6, 1, 1, 3'b100, 1, 1, 1, 0);
    tick();
    drive(1, 16'hBBBB, 3'd7, 1, 0, 3'b000, 0, 0, 0, 0);
    tick();
    check("pre_reset_flags", 32'(FLAGS), 32'b110);
    check("pre_reset_in_ready", 32'(IN_READY), 32'(0));
    pulse_reset("midop");
    drive(0, 16'h0, 3'd0, 0, 0, 3'b000, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("no_stale_out", 32'(OUT_VALID), 32'(0));
      check_all("post_reset");
    end

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 16'($urandom), 3'($urandom),
            1'($urandom), 1'($urandom), 3'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom_range(0, 2) != 0));
      tick();
      check_all("rand");
      if (i == 200) pulse_reset("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
